// File: rtl/onoff_pkg.sv
// Shared state encoding and default parameter values for the on/off channel sequencer.
package onoff_pkg;

    localparam int unsigned DEF_N_CH       = 4;
    localparam int unsigned DEF_SETTLE_CYC = 8;
    localparam int unsigned DEF_MAX_ON     = 3;

    typedef enum logic [0:0] {
        STATE_IDLE,
        STATE_SETTLE
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible channel above last_grant, wrapping around.
module rr_arbiter import onoff_pkg::*; #(
    parameter int unsigned N_CH  = DEF_N_CH,
    parameter int unsigned IDX_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  eligible,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N_CH-1:0]  winner,
    output logic             valid
);

    always_comb begin
        logic [IDX_W-1:0] idx;
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int unsigned off = 1; off <= N_CH; off++) begin
            idx = IDX_W'((32'(last_grant) + off) % N_CH);
            if (!valid && eligible[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/onoff_sequencer.sv
// Rate-limited channel enable sequencer: one turn-on per settle window, capped concurrent ON count.
module onoff_sequencer import onoff_pkg::*; #(
    parameter int unsigned N_CH       = DEF_N_CH,
    parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int unsigned MAX_ON     = DEF_MAX_ON
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [N_CH-1:0] SW_ON,
    input  logic [N_CH-1:0] SW_OFF,
    output logic [N_CH-1:0] ON,
    output logic [N_CH-1:0] GRANT,
    output logic            BUSY
);

    localparam int unsigned IDX_W = $clog2(N_CH);
    localparam int unsigned CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int unsigned ACT_W = $clog2(N_CH + 1);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [ACT_W-1:0] MAX_ACT  = ACT_W'(MAX_ON);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_CH - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_CH-1:0]   on_q, on_d;
    logic [N_CH-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]  last_q, last_d;

    logic [N_CH-1:0]   eligible;
    logic [N_CH-1:0]   on_kept;
    logic [ACT_W-1:0]  active;
    logic [N_CH-1:0]   win;
    logic              win_valid;
    logic [IDX_W-1:0]  win_idx;

    // Turn-offs take effect this cycle, so the cap is judged on what survives them.
    assign on_kept  = on_q & ~SW_OFF;
    assign eligible = SW_ON & ~SW_OFF & ~on_q;

    always_comb begin
        active = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            active = active + ACT_W'(on_kept[i]);
        end
    end

    rr_arbiter #(
        .N_CH  (N_CH),
        .IDX_W (IDX_W)
    ) u_arb (
        .eligible   (eligible),
        .last_grant (last_q),
        .winner     (win),
        .valid      (win_valid)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (win[i]) begin
                win_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        on_d    = on_kept;
        grant_d = '0;
        last_d  = last_q;
        unique case (state_q)
            STATE_IDLE: begin
                if (win_valid && (active < MAX_ACT)) begin
                    on_d    = on_kept | win;
                    grant_d = win;
                    last_d  = win_idx;
                    cnt_d   = CNT_LOAD;
                    state_d = STATE_SETTLE;
                end
            end
            STATE_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = STATE_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = STATE_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= STATE_IDLE;
            cnt_q   <= '0;
            on_q    <= '0;
            grant_q <= '0;
            last_q  <= LAST_RST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            on_q    <= on_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    assign ON    = on_q;
    assign GRANT = grant_q;
    assign BUSY  = (state_q == STATE_SETTLE);

endmodule

// File: tb/tb_onoff_sequencer.sv
// Directed and randomized checks of onoff_sequencer against a timestamp-based reference model.
module tb_onoff_sequencer;

    localparam int N  = 4;
    localparam int SC = 8;
    localparam int MX = 3;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [N-1:0] SW_ON = '0;
    logic [N-1:0] SW_OFF = '0;
    logic [N-1:0] ON;
    logic [N-1:0] GRANT;
    logic         BUSY;

    int tests = 0;
    int fails = 0;

    // Model: grants are spaced by edge timestamps rather than an FSM.
    int           edge_no   = 0;
    int           g_edge    = -1000;
    int           m_last    = N - 1;
    logic [N-1:0] m_on      = '0;
    logic [N-1:0] exp_grant = '0;
    logic         exp_busy  = 1'b0;

    onoff_sequencer #(
        .N_CH       (N),
        .SETTLE_CYC (SC),
        .MAX_ON     (MX)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .SW_ON  (SW_ON),
        .SW_OFF (SW_OFF),
        .ON     (ON),
        .GRANT  (GRANT),
        .BUSY   (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_no);
        end
    endtask

    task automatic model(input logic [N-1:0] on_r, input logic [N-1:0] off_r, input logic rst);
        logic [N-1:0] elig;
        logic [N-1:0] nxt;
        int           act;
        edge_no++;
        exp_grant = '0;
        if (rst) begin
            m_on   = '0;
            m_last = N - 1;
            g_edge = -1000;
        end else begin
            elig = on_r & ~off_r & ~m_on;
            nxt  = m_on & ~off_r;
            act  = $countones(nxt);
            if ((edge_no - g_edge >= SC + 1) && (elig != 0) && (act < MX)) begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (m_last + k) % N;
                    if (exp_grant == 0 && elig[c]) begin
                        exp_grant[c] = 1'b1;
                        m_last       = c;
                    end
                end
                g_edge = edge_no;
                nxt    = nxt | exp_grant;
            end
            m_on = nxt;
        end
        exp_busy = (edge_no - g_edge) < SC;
    endtask

    task automatic step(input logic [N-1:0] on_r, input logic [N-1:0] off_r, input logic rst);
        SW_ON  = on_r;
        SW_OFF = off_r;
        RST    = rst;
        model(on_r, off_r, rst);
        @(posedge CLK);
        #1;
        chk("on", 32'(ON), 32'(m_on));
        chk("grant", 32'(GRANT), 32'(exp_grant));
        chk("busy", 32'(BUSY), 32'(exp_busy));
        chk("grant_onehot0", 32'($onehot0(GRANT)), 1);
        chk("on_count_le_max", 32'($countones(ON) <= MX), 1);
        chk("grant_subset_on", 32'((GRANT & ~ON) == 0), 1);
    endtask

    initial begin
        // All requests held: ch0, ch1, ch2 at edges 1, 10, 19; cap blocks ch3.
        step('0, '0, 1'b1);
        chk("reset_on", 32'(ON), 0);
        chk("reset_busy", 32'(BUSY), 0);
        for (int i = 1; i <= 30; i++) begin
            step(4'b1111, 4'b0000, 1'b0);
            if (i == 1)  chk("rr_first_ch0", 32'(GRANT), 32'h1);
            if (i == 10) chk("rr_second_ch1", 32'(GRANT), 32'h2);
            if (i == 19) chk("rr_third_ch2", 32'(GRANT), 32'h4);
        end
        chk("cap_on_0111", 32'(ON), 32'h7);

        // Free a slot by turning ch0 off while ch3 requests.
        step(4'b1000, 4'b0001, 1'b0);
        chk("slot_freed_grant_ch3", 32'(GRANT), 32'h8);
        chk("slot_freed_on", 32'(ON), 32'hE);
        for (int i = 0; i < 4; i++) step(4'b1000, 4'b0000, 1'b0);

        // Simultaneous on/off never grants.
        step('0, '0, 1'b1);
        for (int i = 0; i < 12; i++) step(4'b0010, 4'b0010, 1'b0);
        chk("on_off_conflict_on", 32'(ON), 0);

        // Granted channel turned off mid-settle; settle still completes.
        step('0, '0, 1'b1);
        step(4'b0010, 4'b0000, 1'b0);
        chk("ch1_granted", 32'(GRANT), 32'h2);
        for (int i = 2; i <= 10; i++) begin
            step(4'b0100, (i == 4) ? 4'b0010 : 4'b0000, 1'b0);
            if (i == 4)  chk("ch1_off_mid_settle", 32'(ON), 0);
            if (i == 8)  chk("busy_still_high", 32'(BUSY), 1);
            if (i == 10) chk("ch2_after_settle", 32'(GRANT), 32'h4);
        end

        // Reset during settle, then immediate grant after release.
        step('0, '0, 1'b1);
        for (int i = 1; i <= 10; i++) step(4'b0011, 4'b0000, 1'b0);
        chk("pre_reset_on_0011", 32'(ON), 32'h3);
        for (int i = 0; i < 3; i++) step(4'b0000, 4'b0000, 1'b0);
        step(4'b0100, 4'b0000, 1'b1);
        chk("mid_settle_reset_on", 32'(ON), 0);
        chk("mid_settle_reset_busy", 32'(BUSY), 0);
        step(4'b0100, 4'b0000, 1'b0);
        chk("grant_after_reset", 32'(GRANT), 32'h4);

        // Randomized traffic with sparse turn-offs and occasional resets.
        for (int i = 0; i < 600; i++) begin
            logic [N-1:0] r_on;
            logic [N-1:0] r_off;
            logic         r_rst;
            r_on  = N'($urandom);
            r_off = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            r_rst = ($urandom_range(0, 59) == 0);
            step(r_on, r_off, r_rst);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
